// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-issue instruction fetch sequencer with branch/jump redirect and retire counter.
// Define FETCH_DELAY_SLOT_EN to redirect after one delay-slot instruction instead of immediately.
module fetch_ctrl #(
    parameter logic [29:0] RESET_PC = 30'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        br_taken,
    input  logic        jump,
    input  logic        halt,
    input  logic [15:0] imm16,
    input  logic [25:0] target26,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALTED} state_t;

    state_t      state_q, state_d;
    logic [29:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;
    logic        imem_req_q, imem_req_d;
    logic        instr_valid_q, instr_valid_d;

    logic [29:0] pc_plus1;
    logic [29:0] redirect_pc;
    logic        redirect;

`ifdef FETCH_DELAY_SLOT_EN
    logic        pend_valid_q, pend_valid_d;
    logic [29:0] pend_pc_q, pend_pc_d;
`endif

    assign pc_plus1 = pc_q + 30'd1;
    assign redirect = jump | br_taken;

    // Jump takes priority over a simultaneously taken branch.
    always_comb begin
        if (jump) begin
            redirect_pc = {pc_plus1[29:26], target26};
        end else begin
            redirect_pc = pc_plus1 + {{14{imm16[15]}}, imm16};
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
`ifdef FETCH_DELAY_SLOT_EN
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
`endif
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (exec_done) begin
                    retired_d = retired_q + 32'd1;
                    state_d   = halt ? HALTED : FETCH;
`ifdef FETCH_DELAY_SLOT_EN
                    // The delay-slot instruction consumes the pending target and cannot redirect itself.
                    if (pend_valid_q) begin
                        pc_d         = pend_pc_q;
                        pend_valid_d = 1'b0;
                    end else begin
                        pc_d = pc_plus1;
                        if (redirect) begin
                            pend_valid_d = 1'b1;
                            pend_pc_d    = redirect_pc;
                        end
                    end
`else
                    pc_d = redirect ? redirect_pc : pc_plus1;
`endif
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
        imem_req_d    = (state_d == FETCH);
        instr_valid_d = (state_d == ISSUE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            retired_q     <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
`ifdef FETCH_DELAY_SLOT_EN
            pend_valid_q  <= 1'b0;
            pend_pc_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            retired_q     <= retired_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
`ifdef FETCH_DELAY_SLOT_EN
            pend_valid_q  <= pend_valid_d;
            pend_pc_q     <= pend_pc_d;
`endif
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign retired     = retired_q;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 30'h0, is the word address fetched first after reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  30  word address of the request; byte address is {imem_addr,2'b00}.
REQ-006 imem_ready  input  1  memory has imem_rdata valid this cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 instr  output  32  registered instruction presented to decode/execute.
REQ-009 instr_valid  output  1  instr is valid and awaiting completion.
REQ-010 exec_done  input  1  execute has finished instr; br_taken, jump, halt, imm16 and target26 are valid this cycle.
REQ-011 br_taken  input  1  conditional branch taken.
REQ-012 jump  input  1  unconditional jump, active-high.
REQ-013 halt  input  1  stop fetching after this instruction.
REQ-014 imm16  input  16  signed word offset for the branch.
REQ-015 target26  input  26  jump target field.
REQ-016 retired  output  32  count of completed instructions.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, ISSUE and HALTED, with state IDLE held while reset_n is low.
REQ-018 IDLE SHALL go to FETCH on the first edge with reset_n high.
REQ-019 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; imem_req SHALL be 0 in every other state.
REQ-020 In FETCH with imem_ready=1, the block SHALL latch instr<=imem_rdata and go to ISSUE on that edge, and SHALL NOT wait a cycle when ready arrives in the first request cycle.
REQ-021 In ISSUE, instr_valid SHALL be 1 and instr SHALL be held stable; instr_valid SHALL be 0 in all other states.
REQ-022 exec_done SHALL be ignored outside ISSUE, and imem_ready SHALL be ignored outside FETCH.
REQ-023 On exec_done in ISSUE: retired SHALL increment by 1 (modulo 2^32) and pc SHALL update per REQ-024..REQ-027.
REQ-024 On exec_done in ISSUE: state SHALL go to HALTED if halt=1, else to FETCH.
REQ-025 Sequential next pc SHALL be pc+1, 30-bit, wrapping 30'h3FFFFFFF to 0.
REQ-026 Branch next pc SHALL be pc+1+sign_extend30(imm16), 30-bit, discarding overflow.
REQ-027 Jump next pc SHALL be {pc_plus1[29:26], target26}.
REQ-028 When jump and br_taken are both 1, jump SHALL win.
REQ-029 HALTED SHALL be left only by reset; retired and pc SHALL hold in HALTED.
REQ-030 Minimum issue interval SHALL be 2 cycles per instruction: 1 FETCH cycle with ready, plus 1 ISSUE cycle with exec_done.

Reset
REQ-031 On a reset_n=0 edge, the block SHALL set state=IDLE, pc=RESET_PC, instr=0, retired=0 and, if compiled in, the pending-redirect register to empty.
REQ-032 Reset asserted mid-FETCH or mid-ISSUE SHALL abort the operation: imem_req and instr_valid SHALL be 0 in the cycle after the reset edge, and no retire SHALL be counted.

Configuration
REQ-033 The macro FETCH_DELAY_SLOT_EN SHALL select between delay-slot and immediate redirect behaviour.
REQ-034 With FETCH_DELAY_SLOT_EN defined:
  - a taken branch/jump SHALL store its target in a pending register and set pc=pc+1, so the delay-slot instruction is fetched and issued.
  - on the delay slot's exec_done, pc SHALL equal the pending target.
  - br_taken and jump asserted by the delay-slot instruction SHALL be ignored.
  - halt in the delay slot SHALL still be honoured.
REQ-035 With FETCH_DELAY_SLOT_EN undefined, the target SHALL be loaded into pc directly on exec_done, and no pending register SHALL exist.

Verification
REQ-036 Sequential run: RESET_PC=0, imem_ready=1 always, exec_done=1 in every ISSUE cycle, for 8 instructions -> imem_addr sequence 0,1,...,7; retired=8.
REQ-037 Jump: pc=5 with jump=1, target26=26'hC -> next imem_addr=30'hC; with br_taken=1 also set -> still 30'hC.
REQ-038 Branch offsets:
  - pc=12 with br_taken=1, imm16=16'h0003 -> next imem_addr=16.
  - pc=16 with imm16=16'hFFFE -> next imem_addr=15.
  - pc=0 with imm16=16'hFFFE -> next imem_addr=30'h3FFFFFFF.
REQ-039 Stalls:
  - imem_ready held 0 for 5 cycles -> imem_req stays 1 and imem_addr stays constant.
  - exec_done held 0 -> instr_valid stays 1 and instr stays unchanged.
REQ-040 Reset asserted during FETCH at pc=9 -> next cycle state IDLE, imem_req=0, retired=0; after release, imem_addr=RESET_PC.
REQ-041 Delay slot and halt:
  - With FETCH_DELAY_SLOT_EN, a jump at pc=3 to target26=26'h20 -> imem_addr sequence 4, then 30'h20.
  - A halt at exec_done -> imem_req stays 0 indefinitely and retired is frozen.
